ctrl_pipe_stages: RTL and testbench

- Consumer end of the decoder's 9-bit control word and 2-bit ALU op. Carries the decoded control through the ID/EX, EX/MEM and MEM/WB pipeline registers of the 16-bit RISC core.
- Splits out per-stage enables and resolves branches and jumps in MEM.
- Inserts bubbles on stall and flushes younger stages on a taken redirect.
- Sits between the decoder output and the datapath muxes, memory enables and PC select.

---
 rtl/ctrl_pipe_stages.sv | 179 +++++++++++++++++
 tb/tb_ctrl_pipe_stages.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_stages.sv
// ID/EX, EX/MEM and MEM/WB control pipeline with MEM-stage branch/jump resolution.
// Optional CTRL_PIPE_PERF_EN adds saturating bubble and redirect counters.
module ctrl_pipe_stages #(
    parameter int CTRL_W  = 9,
    parameter int ALUOP_W = 2,
    parameter int PERF_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid_i,
    input  logic [CTRL_W-1:0]  id_ctrl_i,
    input  logic [ALUOP_W-1:0] id_alu_op_i,
    input  logic               stall_i,
    input  logic               ex_zero_i,
    output logic               ex_alu_src_o,
    output logic               ex_reg_dst_o,
    output logic [ALUOP_W-1:0] ex_alu_op_o,
    output logic               mem_write_en_o,
    output logic               mem_read_en_o,
    output logic               pc_redirect_o,
    output logic               pc_redirect_is_jump_o,
    output logic               wb_write_en_o,
    output logic               wb_mem_to_reg_o,
    output logic [PERF_W-1:0]  perf_bubbles_o,
    output logic [PERF_W-1:0]  perf_redirects_o
);

    localparam int B_BNE = 8;
    localparam int B_WE  = 7;
    localparam int B_M2R = 6;
    localparam int B_RD  = 5;
    localparam int B_AS  = 4;
    localparam int B_MW  = 3;
    localparam int B_MR  = 2;
    localparam int B_BEQ = 1;
    localparam int B_J   = 0;

    // ID/EX
    logic               idex_v_q,   idex_v_d;
    logic [CTRL_W-1:0]  idex_ctrl_q, idex_ctrl_d;
    logic [ALUOP_W-1:0] idex_aluop_q, idex_aluop_d;

    // EX/MEM
    logic exmem_v_q,   exmem_v_d;
    logic exmem_we_q,  exmem_we_d;
    logic exmem_m2r_q, exmem_m2r_d;
    logic exmem_mw_q,  exmem_mw_d;
    logic exmem_mr_q,  exmem_mr_d;
    logic exmem_beq_q, exmem_beq_d;
    logic exmem_bne_q, exmem_bne_d;
    logic exmem_j_q,   exmem_j_d;
    logic exmem_z_q,   exmem_z_d;

    // MEM/WB
    logic memwb_v_q,   memwb_v_d;
    logic memwb_we_q,  memwb_we_d;
    logic memwb_m2r_q, memwb_m2r_d;

    logic take;

    assign take = exmem_v_q & ((exmem_beq_q & exmem_z_q) |
                               (exmem_bne_q & ~exmem_z_q) |
                               exmem_j_q);

    always_comb begin
        idex_v_d     = 1'b0;
        idex_ctrl_d  = '0;
        idex_aluop_d = '0;
        // Flush outranks stall; both simply load a bubble here.
        if (!take && !stall_i && id_valid_i) begin
            idex_v_d     = 1'b1;
            idex_ctrl_d  = id_ctrl_i;
            idex_aluop_d = id_alu_op_i;
        end

        exmem_v_d   = 1'b0;
        exmem_we_d  = 1'b0;
        exmem_m2r_d = 1'b0;
        exmem_mw_d  = 1'b0;
        exmem_mr_d  = 1'b0;
        exmem_beq_d = 1'b0;
        exmem_bne_d = 1'b0;
        exmem_j_d   = 1'b0;
        exmem_z_d   = 1'b0;
        if (!take) begin
            exmem_v_d   = idex_v_q;
            exmem_we_d  = idex_ctrl_q[B_WE];
            exmem_m2r_d = idex_ctrl_q[B_M2R];
            exmem_mw_d  = idex_ctrl_q[B_MW];
            exmem_mr_d  = idex_ctrl_q[B_MR];
            exmem_beq_d = idex_ctrl_q[B_BEQ];
            exmem_bne_d = idex_ctrl_q[B_BNE];
            exmem_j_d   = idex_ctrl_q[B_J];
            exmem_z_d   = ex_zero_i;
        end

        // The redirecting instruction itself still retires into MEM/WB.
        memwb_v_d   = exmem_v_q;
        memwb_we_d  = exmem_we_q;
        memwb_m2r_d = exmem_m2r_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_v_q     <= 1'b0;
            idex_ctrl_q  <= '0;
            idex_aluop_q <= '0;
            exmem_v_q    <= 1'b0;
            exmem_we_q   <= 1'b0;
            exmem_m2r_q  <= 1'b0;
            exmem_mw_q   <= 1'b0;
            exmem_mr_q   <= 1'b0;
            exmem_beq_q  <= 1'b0;
            exmem_bne_q  <= 1'b0;
            exmem_j_q    <= 1'b0;
            exmem_z_q    <= 1'b0;
            memwb_v_q    <= 1'b0;
            memwb_we_q   <= 1'b0;
            memwb_m2r_q  <= 1'b0;
        end else begin
            idex_v_q     <= idex_v_d;
            idex_ctrl_q  <= idex_ctrl_d;
            idex_aluop_q <= idex_aluop_d;
            exmem_v_q    <= exmem_v_d;
            exmem_we_q   <= exmem_we_d;
            exmem_m2r_q  <= exmem_m2r_d;
            exmem_mw_q   <= exmem_mw_d;
            exmem_mr_q   <= exmem_mr_d;
            exmem_beq_q  <= exmem_beq_d;
            exmem_bne_q  <= exmem_bne_d;
            exmem_j_q    <= exmem_j_d;
            exmem_z_q    <= exmem_z_d;
            memwb_v_q    <= memwb_v_d;
            memwb_we_q   <= memwb_we_d;
            memwb_m2r_q  <= memwb_m2r_d;
        end
    end

    assign ex_alu_src_o          = idex_v_q & idex_ctrl_q[B_AS];
    assign ex_reg_dst_o          = idex_v_q & idex_ctrl_q[B_RD];
    assign ex_alu_op_o           = {ALUOP_W{idex_v_q}} & idex_aluop_q;
    assign mem_write_en_o        = exmem_v_q & exmem_mw_q;
    assign mem_read_en_o         = exmem_v_q & exmem_mr_q;
    assign pc_redirect_o         = take;
    assign pc_redirect_is_jump_o = exmem_v_q & exmem_j_q;
    assign wb_write_en_o         = memwb_v_q & memwb_we_q;
    assign wb_mem_to_reg_o       = memwb_v_q & memwb_m2r_q;

`ifdef CTRL_PIPE_PERF_EN
    logic [PERF_W-1:0] perf_bub_q, perf_bub_d;
    logic [PERF_W-1:0] perf_red_q, perf_red_d;

    always_comb begin
        perf_bub_d = perf_bub_q;
        perf_red_d = perf_red_q;
        if (stall_i && !take && perf_bub_q != '1)
            perf_bub_d = perf_bub_q + PERF_W'(1);
        if (take && perf_red_q != '1)
            perf_red_d = perf_red_q + PERF_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_bub_q <= '0;
            perf_red_q <= '0;
        end else begin
            perf_bub_q <= perf_bub_d;
            perf_red_q <= perf_red_d;
        end
    end

    assign perf_bubbles_o   = perf_bub_q;
    assign perf_redirects_o = perf_red_q;
`else
    assign perf_bubbles_o   = '0;
    assign perf_redirects_o = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_stages.sv
// Directed-vector bench for ctrl_pipe_stages; perf checks follow CTRL_PIPE_PERF_EN.
module tb_ctrl_pipe_stages;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [8:0]  id_ctrl = '0;
    logic [1:0]  id_alu_op = '0;
    logic        stall = 1'b0;
    logic        ex_zero = 1'b0;
    logic        ex_alu_src, ex_reg_dst, mem_write_en, mem_read_en;
    logic        pc_redirect, pc_redirect_is_jump, wb_write_en, wb_mem_to_reg;
    logic [1:0]  ex_alu_op;
    logic [15:0] perf_bubbles, perf_redirects;

    int nvec = 0;
    int nerr = 0;

    localparam logic [8:0] LW  = 9'h0D4;
    localparam logic [8:0] SW  = 9'h018;
    localparam logic [8:0] RT  = 9'h0A0;
    localparam logic [8:0] BEQ = 9'h002;
    localparam logic [8:0] BNE = 9'h100;
    localparam logic [8:0] JMP = 9'h001;

    ctrl_pipe_stages dut (
        .clk                   (clk),
        .rst                   (rst),
        .id_valid_i            (id_valid),
        .id_ctrl_i             (id_ctrl),
        .id_alu_op_i           (id_alu_op),
        .stall_i               (stall),
        .ex_zero_i             (ex_zero),
        .ex_alu_src_o          (ex_alu_src),
        .ex_reg_dst_o          (ex_reg_dst),
        .ex_alu_op_o           (ex_alu_op),
        .mem_write_en_o        (mem_write_en),
        .mem_read_en_o         (mem_read_en),
        .pc_redirect_o         (pc_redirect),
        .pc_redirect_is_jump_o (pc_redirect_is_jump),
        .wb_write_en_o         (wb_write_en),
        .wb_mem_to_reg_o       (wb_mem_to_reg),
        .perf_bubbles_o        (perf_bubbles),
        .perf_redirects_o      (perf_redirects)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one edge; inputs applied after this return are sampled at the next edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [8:0] c, input logic [1:0] op);
        id_valid  = 1'b1;
        id_ctrl   = c;
        id_alu_op = op;
    endtask

    task automatic idle();
        id_valid  = 1'b0;
        id_ctrl   = '0;
        id_alu_op = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        stall   = 1'b0;
        ex_zero = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        chk("rst_ex", {13'd0, ex_alu_src, ex_reg_dst, 1'b0} | {14'd0, ex_alu_op}, 16'd0);
        chk("rst_mem", {14'd0, mem_write_en, mem_read_en}, 16'd0);
        chk("rst_redir", {14'd0, pc_redirect, pc_redirect_is_jump}, 16'd0);
        chk("rst_wb", {14'd0, wb_write_en, wb_mem_to_reg}, 16'd0);
        chk("rst_perf", perf_bubbles | perf_redirects, 16'd0);
        $display("tb: test_reset done");
    endtask

    task automatic test_lw();
        do_reset();
        issue(LW, 2'b10);
        cyc();
        idle();
        chk("lw_ex_alu_src", {15'd0, ex_alu_src}, 16'd1);
        chk("lw_ex_reg_dst", {15'd0, ex_reg_dst}, 16'd0);
        chk("lw_ex_alu_op", {14'd0, ex_alu_op}, 16'd2);
        cyc();
        chk("lw_mem_read", {15'd0, mem_read_en}, 16'd1);
        chk("lw_mem_write", {15'd0, mem_write_en}, 16'd0);
        chk("lw_ex_idle", {14'd0, ex_alu_op}, 16'd0);
        cyc();
        chk("lw_wb_we", {15'd0, wb_write_en}, 16'd1);
        chk("lw_wb_m2r", {15'd0, wb_mem_to_reg}, 16'd1);
        chk("lw_mem_idle", {15'd0, mem_read_en}, 16'd0);
        cyc();
        chk("lw_wb_done", {15'd0, wb_write_en}, 16'd0);
        $display("tb: test_lw done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(SW, 2'b00);
        cyc();
        issue(RT, 2'b01);
        chk("sw_ex_alu_src", {15'd0, ex_alu_src}, 16'd1);
        cyc();
        idle();
        chk("sw_mem_write", {15'd0, mem_write_en}, 16'd1);
        chk("rt_ex_reg_dst", {15'd0, ex_reg_dst}, 16'd1);
        chk("rt_ex_alu_op", {14'd0, ex_alu_op}, 16'd1);
        cyc();
        chk("rt_mem_strobes", {14'd0, mem_write_en, mem_read_en}, 16'd0);
        chk("sw_wb_we", {15'd0, wb_write_en}, 16'd0);
        cyc();
        chk("rt_wb_we", {15'd0, wb_write_en}, 16'd1);
        chk("rt_wb_m2r", {15'd0, wb_mem_to_reg}, 16'd0);
        $display("tb: test_back_to_back done");
    endtask

    task automatic test_beq_flush();
        int wb_seen;
        do_reset();
        issue(BEQ, 2'b01);
        cyc();
        issue(RT, 2'b00);
        ex_zero = 1'b1;
        cyc();
        issue(RT, 2'b00);
        ex_zero = 1'b0;
        chk("beq_redirect", {15'd0, pc_redirect}, 16'd1);
        chk("beq_is_jump", {15'd0, pc_redirect_is_jump}, 16'd0);
        cyc();
        idle();
        chk("beq_redirect_once", {15'd0, pc_redirect}, 16'd0);
        chk("beq_flush_ex", {14'd0, ex_reg_dst, ex_alu_src}, 16'd0);
        wb_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (wb_write_en) wb_seen++;
            cyc();
        end
        chk("beq_younger_no_wb", 16'(wb_seen), 16'd0);
        $display("tb: test_beq_flush done");
    endtask

    task automatic test_bne();
        do_reset();
        issue(BNE, 2'b01);
        cyc();
        issue(RT, 2'b00);
        ex_zero = 1'b1;
        cyc();
        idle();
        ex_zero = 1'b0;
        chk("bne_z1_no_redirect", {15'd0, pc_redirect}, 16'd0);
        cyc();
        cyc();
        chk("bne_z1_follower_wb", {15'd0, wb_write_en}, 16'd1);
        do_reset();
        issue(BNE, 2'b01);
        cyc();
        idle();
        ex_zero = 1'b0;
        cyc();
        chk("bne_z0_redirect", {15'd0, pc_redirect}, 16'd1);
        $display("tb: test_bne done");
    endtask

    task automatic test_jump_stall();
        do_reset();
        issue(JMP, 2'b00);
        cyc();
        idle();
        cyc();
        issue(RT, 2'b00);
        stall = 1'b1;
        chk("j_redirect", {15'd0, pc_redirect}, 16'd1);
        chk("j_is_jump", {15'd0, pc_redirect_is_jump}, 16'd1);
        cyc();
        stall = 1'b0;
        idle();
        chk("j_flush_ex", {14'd0, ex_reg_dst, ex_alu_src}, 16'd0);
        chk("j_flush_mem", {15'd0, pc_redirect}, 16'd0);
`ifdef CTRL_PIPE_PERF_EN
        chk("j_perf_redirects", perf_redirects, 16'd1);
        chk("j_perf_bubbles", perf_bubbles, 16'd0);
`else
        chk("j_perf_tied_off", perf_redirects | perf_bubbles, 16'd0);
`endif
        $display("tb: test_jump_stall done");
    endtask

    task automatic test_stall_bubble();
        do_reset();
        issue(LW, 2'b10);
        stall = 1'b1;
        cyc();
        stall = 1'b0;
        chk("stall_ex_bubble", {13'd0, ex_alu_src, ex_alu_op}, 16'd0);
`ifdef CTRL_PIPE_PERF_EN
        chk("stall_perf_bubbles", perf_bubbles, 16'd1);
`endif
        cyc();
        idle();
        chk("stall_held_word_ex", {15'd0, ex_alu_src}, 16'd1);
        $display("tb: test_stall_bubble done");
    endtask

    task automatic test_reset_mid();
        int wb_seen;
        do_reset();
        issue(LW, 2'b10);
        cyc();
        idle();
        cyc();
        chk("mid_mem_read_before", {15'd0, mem_read_en}, 16'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_mem_read_async", {15'd0, mem_read_en}, 16'd0);
        cyc();
        rst = 1'b0;
        wb_seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (wb_write_en) wb_seen++;
            cyc();
        end
        chk("mid_no_wb", 16'(wb_seen), 16'd0);
        $display("tb: test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_lw();
        test_back_to_back();
        test_beq_flush();
        test_bne();
        test_jump_stall();
        test_stall_bubble();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
